// File: rtl/logic_unit_arbiter_if.sv
// Request/response bus between the requesters and the shared logic-op unit.
interface logic_unit_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic [7:0]            done_cnt;

  // Requester / response-consumer side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_err, done_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, rsp_err, done_cnt
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic-op unit among NREQ requesters.
// One transaction in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold until consumed).
module logic_unit_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  logic_unit_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpXor  = 3'b010;
  localparam logic [2:0] OpNand = 3'b011;
  localparam logic [2:0] OpNor  = 3'b100;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IDW-1:0]   r_last;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_y;
  logic             r_err;
  logic [IDW-1:0]   r_rsp_id;
  logic [7:0]       r_done_cnt;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_accept;
  logic             w_rsp_valid;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  // Round-robin search starting one past the last granted requester, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!w_found && bus.req_valid[(32'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_grant = IDW'((32'(r_last) + k) % NREQ);
      end
    end
  end

  // One-hot ready to the winner only while idle; reset masks everything.
  always_comb begin
    w_req_ready = '0;
    if (r_state == StIdle && w_found && !reset) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  assign w_accept    = |(bus.req_valid & w_req_ready);
  assign w_rsp_valid = (r_state == StResp) && !reset;
  assign w_rsp_fire  = w_rsp_valid && bus.rsp_ready;

  // Bitwise op on the latched operands; illegal codes give zero with err set.
  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (r_op)
      OpAnd:   w_y = r_a & r_b;
      OpOr:    w_y = r_a | r_b;
      OpXor:   w_y = r_a ^ r_b;
      OpNand:  w_y = ~(r_a & r_b);
      OpNor:   w_y = ~(r_a | r_b);
      default: w_err = 1'b1;
    endcase
  end

  // Next-state logic for the single-transaction sequencer.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (w_rsp_fire) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Operand capture, result registers and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= IDW'(NREQ - 1);
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= '0;
      r_y        <= '0;
      r_err      <= 1'b0;
      r_rsp_id   <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.req_op[3*int'(w_grant) +: 3];
        r_a    <= bus.req_a[WIDTH*int'(w_grant) +: WIDTH];
        r_b    <= bus.req_b[WIDTH*int'(w_grant) +: WIDTH];
        r_id   <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == StExec) begin
        r_y      <= w_y;
        r_err    <= w_err;
        r_rsp_id <= r_id;
      end
      if (w_rsp_fire) begin
        r_done_cnt <= r_done_cnt + 8'd1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_y     = r_y;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_err;
  assign bus.done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: vector table plus multi-cycle sequences.
module tb_logic_unit_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] req;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       err;
    logic [1:0] id;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_done = 0;
  vec_t vecs[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] model(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      default: return 5'b1_0000;
    endcase
  endfunction

  task automatic load_req(input int r, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b);
    bus.req_op[3*r +: 3] = op;
    bus.req_a[4*r +: 4]  = a;
    bus.req_b[4*r +: 4]  = b;
  endtask

  // All requesters valid, rsp_ready high; scoreboard every response, check
  // round-robin order (from reset, so req0 first) and the 3-cycle issue spacing.
  task automatic run_stream(input int n);
    int n_acc = 0;
    int n_rsp = 0;
    int last_cyc = 0;
    int g;
    logic [3:0] acc;
    logic [4:0] m;
    exp_t e;
    for (int r = 0; r < 4; r++) load_req(r, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    sb.delete();
    for (int cyc = 0; cyc < 3 * n + 20 && n_rsp < n; cyc++) begin
      #1;
      acc = bus.req_valid & bus.req_ready;
      g = -1;
      for (int k = 0; k < 4; k++) if (acc[k]) g = k;
      if (acc != 4'b0) begin
        check("rr_order", 32'(g), 32'(n_acc % 4));
        if (n_acc > 0) check("issue_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        m = model(bus.req_op[3*g +: 3], bus.req_a[4*g +: 4], bus.req_b[4*g +: 4]);
        e.y = m[3:0];
        e.err = m[4];
        e.id = 2'(g);
        sb.push_back(e);
        n_acc++;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("stream_rsp", {25'd0, bus.rsp_err, bus.rsp_id, bus.rsp_y},
                {25'd0, e.err, e.id, e.y});
        end
        n_rsp++;
      end
      step();
      if (g >= 0) load_req(g, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    end
    bus.req_valid = 4'h0;
    check("stream_rsp_count", 32'(n_rsp), 32'(n));
    check("stream_acc_count", 32'(n_acc), 32'(n));
    check("stream_done_cnt", 32'(bus.done_cnt), 32'(n % 256));
  endtask

  logic [3:0] held_y;
  logic [1:0] held_id;

  initial begin
    vecs[0]  = '{2'd0, 3'b000, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[1]  = '{2'd2, 3'b000, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[2]  = '{2'd2, 3'b001, 4'hC, 4'hA, 4'hE, 1'b0};
    vecs[3]  = '{2'd2, 3'b010, 4'hC, 4'hA, 4'h6, 1'b0};
    vecs[4]  = '{2'd2, 3'b011, 4'hC, 4'hA, 4'h7, 1'b0};
    vecs[5]  = '{2'd2, 3'b100, 4'hC, 4'hA, 4'h1, 1'b0};
    vecs[6]  = '{2'd1, 3'b110, 4'hC, 4'hA, 4'h0, 1'b1};
    vecs[7]  = '{2'd3, 3'b101, 4'hF, 4'hF, 4'h0, 1'b1};
    vecs[8]  = '{2'd3, 3'b111, 4'h3, 4'h5, 4'h0, 1'b1};
    vecs[9]  = '{2'd1, 3'b010, 4'h5, 4'hF, 4'hA, 1'b0};
    vecs[10] = '{2'd0, 3'b001, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[11] = '{2'd3, 3'b011, 4'hF, 4'hF, 4'h0, 1'b0};

    // Reset with every requester asserting valid: nothing may be granted.
    reset = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    reset = 1'b0;
    bus.req_valid = 4'h0;

    // Single transactions from the table; latency accept t -> rsp_valid at t+2.
    foreach (vecs[i]) begin
      load_req(int'(vecs[i].req), vecs[i].op, vecs[i].a, vecs[i].b);
      bus.req_valid = 4'b0001 << vecs[i].req;
      #1;
      check("vec_req_ready", 32'(bus.req_ready), 32'(4'b0001 << vecs[i].req));
      step();
      bus.req_valid = 4'h0;
      check("vec_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
      step();
      check("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("vec_rsp_y", 32'(bus.rsp_y), 32'(vecs[i].y));
      check("vec_rsp_id", 32'(bus.rsp_id), 32'(vecs[i].req));
      check("vec_rsp_err", 32'(bus.rsp_err), 32'(vecs[i].err));
      step();
      exp_done++;
      check("vec_done_cnt", 32'(bus.done_cnt), 32'(exp_done));
    end

    // Backpressure: response held for 5 cycles, no grants while waiting.
    bus.rsp_ready = 1'b0;
    load_req(1, 3'b100, 4'h3, 4'h5);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'h0;
    step();
    bus.req_valid = 4'b0101;
    load_req(0, 3'b000, 4'hF, 4'hF);
    load_req(2, 3'b000, 4'hF, 4'hF);
    held_y = bus.rsp_y;
    held_id = bus.rsp_id;
    check("bp_rsp_y", 32'(held_y), 32'h8);
    check("bp_rsp_id", 32'(held_id), 32'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold", {26'd0, bus.rsp_id, bus.rsp_y}, {26'd0, held_id, held_y});
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_done_cnt", 32'(bus.done_cnt), 32'(exp_done));
      step();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'h0;
    step();
    exp_done++;
    check("bp_done_after", 32'(bus.done_cnt), 32'(exp_done));
    check("bp_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // Reset during EXEC abandons the transaction.
    load_req(2, 3'b001, 4'h1, 4'h2);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'h0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_done = 0;
    check("rst_mid_done_cnt", 32'(bus.done_cnt), 32'd0);
    check("rst_mid_rsp_valid0", 32'(bus.rsp_valid), 32'd0);
    step();
    check("rst_mid_rsp_valid1", 32'(bus.rsp_valid), 32'd0);
    load_req(0, 3'b010, 4'h9, 4'h3);
    load_req(3, 3'b000, 4'hF, 4'hF);
    bus.req_valid = 4'b1001;
    #1;
    check("rst_mid_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = 4'h0;
    step();
    check("rst_mid_rsp_y", {27'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_y[0]}, 32'b1_00_0);
    check("rst_mid_rsp_val", 32'(bus.rsp_y), 32'hA);
    step();

    // Fair rotation with all requesters busy, then a full done_cnt wrap.
    pulse_reset();
    run_stream(6);
    pulse_reset();
    run_stream(256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
